// File: rtl/seq_nibble_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor.
// Slice width, controller states and the operand-width legality check.
package sub_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    function automatic bit width_ok(input int w);
        return (w >= SLICE_W) && ((w % SLICE_W) == 0);
    endfunction

endpackage

// File: rtl/nibble_lookahead_stage.sv
// 4-bit carry-lookahead adder stage: s = x + y + cin, cout = carry out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller owns all sequencing.
module nibble_lookahead_stage (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = x ^ y;
    assign g = x & y;

    // Each carry is flattened from generate/propagate terms, with no ripple chain.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s    = p ^ c[3:0];
    assign cout = c[4];

endmodule

// File: rtl/seq_nibble_subtractor.sv
// Computes a - b - bin one 4-bit slice per clock, LSB slice first.
// Latency: done pulses in the cycle after the NSLICE-th edge following the accept edge.
// Backpressure: start is ignored while busy; results hold until the next accepted start.
module seq_nibble_subtractor
    import sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("seq_nibble_subtractor: WIDTH must be a positive multiple of 4");
    end

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               carry;
    logic [SLICE_W-1:0] x_slice;
    logic [SLICE_W-1:0] y_slice;
    logic [SLICE_W-1:0] sum4;
    logic               c4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (idx == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == CALC);

    // Subtraction as a + ~b + carry; the carry register starts at ~bin.
    assign x_slice =  a_q[int'(idx) * SLICE_W +: SLICE_W];
    assign y_slice = ~b_q[int'(idx) * SLICE_W +: SLICE_W];

    nibble_lookahead_stage u_stage (
        .x    (x_slice),
        .y    (y_slice),
        .cin  (carry),
        .s    (sum4),
        .cout (c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            diff  <= '0;
            bout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                carry <= ~bin;
                idx   <= '0;
                diff  <= '0;
                bout  <= 1'b0;
                ovf   <= 1'b0;
            end else if (state == CALC) begin
                diff[int'(idx) * SLICE_W +: SLICE_W] <= sum4;
                carry <= c4;
                if (last) begin
                    idx  <= '0;
                    bout <= ~c4;
                    // Operand signs differ and the result sign departs from the minuend.
                    ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum4[SLICE_W-1] != a_q[WIDTH-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_nibble_subtractor.sv
// Self-checking bench for seq_nibble_subtractor (WIDTH=8): directed table,
// multi-cycle corner sequences and a back-to-back random sweep against a reference model.
module tb_seq_nibble_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    seq_nibble_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin);
        vec_t r;
        int   u;
        int   s;
        u = int'(ma) - int'(mb) - int'(mbin);
        s = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        r.a    = ma;
        r.b    = mb;
        r.bin  = mbin;
        r.diff = W'(u);
        r.bout = (u < 0);
        r.ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
        return r;
    endfunction

    // Issues one start pulse and checks latency, result and the one-cycle done.
    task automatic run_op(input vec_t v, input string tag);
        int cyc;
        @(negedge clk);
        a = v.a; b = v.b; bin = v.bin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        cyc = 0;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'd2);
        chk({tag, " diff"}, 32'(diff), 32'(v.diff));
        chk({tag, " bout"}, 32'(bout), 32'(v.bout));
        chk({tag, " ovf"}, 32'(ovf), 32'(v.ovf));
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " diff_held"}, 32'(diff), 32'(v.diff));
    endtask

    vec_t tbl[$];
    vec_t expq[$];

    initial begin
        vec_t cur;
        vec_t e;
        int   ndone;
        int   nacc;
        int   cycles;
        int   last_done;
        logic prev_busy;
        localparam int NB = 1000;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;

        tbl.push_back('{a: 8'h5A, b: 8'h23, bin: 1'b0, diff: 8'h37, bout: 1'b0, ovf: 1'b0});
        tbl.push_back('{a: 8'h10, b: 8'h20, bin: 1'b0, diff: 8'hF0, bout: 1'b1, ovf: 1'b0});
        tbl.push_back('{a: 8'h80, b: 8'h01, bin: 1'b0, diff: 8'h7F, bout: 1'b0, ovf: 1'b1});
        tbl.push_back('{a: 8'h00, b: 8'h00, bin: 1'b1, diff: 8'hFF, bout: 1'b1, ovf: 1'b0});
        tbl.push_back('{a: 8'h7F, b: 8'h80, bin: 1'b0, diff: 8'hFF, bout: 1'b1, ovf: 1'b1});
        tbl.push_back('{a: 8'h80, b: 8'h00, bin: 1'b1, diff: 8'h7F, bout: 1'b0, ovf: 1'b1});
        tbl.push_back('{a: 8'hFF, b: 8'hFF, bin: 1'b0, diff: 8'h00, bout: 1'b0, ovf: 1'b0});
        tbl.push_back('{a: 8'hA5, b: 8'h5A, bin: 1'b1, diff: 8'h4A, bout: 1'b0, ovf: 1'b1});

        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        chk("reset ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // start re-pulsed with new operands while busy must be ignored.
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = (done === 1'b1) ? 1 : 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ndone++;
                chk("busy_ignore diff", 32'(diff), 32'h37);
            end
        end
        chk("busy_ignore done_count", 32'(ndone), 32'd1);

        // Reset mid-operation: immediate clear, no done for the aborted op.
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort diff", 32'(diff), 32'd0);
        chk("abort bout", 32'(bout), 32'd0);
        chk("abort ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        chk("abort no_done", 32'(ndone), 32'd0);
        run_op(model(8'h09, 8'h03, 1'b0), "post_abort");
        chk("post_abort diff_const", 32'(diff), 32'h06);

        // Back-to-back random sweep with start held high.
        @(negedge clk);
        cur = model(W'($urandom), W'($urandom), 1'($urandom));
        a = cur.a; b = cur.b; bin = cur.bin; start = 1'b1;
        prev_busy = 1'b0;
        ndone = 0; nacc = 0; cycles = 0; last_done = 0;
        while (ndone < NB && cycles < 5000) begin
            @(negedge clk);
            cycles++;
            if (busy && !prev_busy) begin
                expq.push_back(cur);
                nacc++;
                if (nacc == NB) start = 1'b0;
                cur = model(W'($urandom), W'($urandom), 1'($urandom));
                a = cur.a; b = cur.b; bin = cur.bin;
            end
            if (done === 1'b1) begin
                if (expq.size() == 0) begin
                    chk("b2b unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = expq.pop_front();
                    chk($sformatf("b2b diff a=%0h b=%0h bin=%0d", e.a, e.b, e.bin), 32'(diff), 32'(e.diff));
                    chk($sformatf("b2b bout a=%0h b=%0h bin=%0d", e.a, e.b, e.bin), 32'(bout), 32'(e.bout));
                    chk($sformatf("b2b ovf a=%0h b=%0h bin=%0d", e.a, e.b, e.bin), 32'(ovf), 32'(e.ovf));
                end
                if (ndone > 0) chk("b2b done_spacing", 32'(cycles - last_done), 32'd3);
                last_done = cycles;
                ndone++;
            end
            prev_busy = busy;
        end
        start = 1'b0;
        chk("b2b completed", 32'(ndone), 32'(NB));

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
